// File: rtl/uart_host_seq.sv
// uart_host_seq: sequences host transmit, configuration and receive traffic onto a
// simple register-mapped UART bus (addr 0 = TX/RX data, addr 1 = status).
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   tx_valid/tx_data       host byte offered for transmit; tx_ready = holding register empty
//   cfg_valid/addr/data    host UART register write request; cfg_ready = sequencer idle
//   rx_valid/rx_data       one-cycle strobe and held received byte
//   uart_int               UART interrupt, active high
//   cs/nrw/addr/datin      UART bus: chip select, read(0)/write(1), address, write data
//   datout                 UART read data, valid the cycle after a read access
module uart_host_seq #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       uart_int,
  output logic       cs,
  output logic       nrw,
  output logic [2:0] addr,
  output logic [7:0] datin,
  input  logic [7:0] datout
);

  localparam int unsigned GAP_W = 8;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(POLL_GAP);

  typedef enum logic [2:0] {
    IDLE, CFG_WR, ST_RD, ST_WAIT, RX_RD, RX_WAIT, TX_WR
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap;
  logic             tx_full;
  logic [7:0]       tx_hold;

  // Single sequencer process; bus outputs are registered together with the state
  // they belong to, so each access lasts exactly one cycle. The addr/datin
  // registers also hold the captured configuration request during CFG_WR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap       <= '0;
      tx_full   <= 1'b0;
      tx_hold   <= 8'h00;
      tx_ready  <= 1'b1;
      cfg_ready <= 1'b1;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      cs        <= 1'b0;
      nrw       <= 1'b0;
      addr      <= 3'd0;
      datin     <= 8'h00;
    end else begin
      cs        <= 1'b0;
      nrw       <= 1'b0;
      addr      <= 3'd0;
      datin     <= 8'h00;
      rx_valid  <= 1'b0;
      cfg_ready <= 1'b0;

      // Holding register accepts in any state while empty.
      if (tx_valid && !tx_full) begin
        tx_full  <= 1'b1;
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_valid) begin
            state <= CFG_WR;
            cs    <= 1'b1;
            nrw   <= 1'b1;
            addr  <= cfg_addr;
            datin <= cfg_data;
          end else if (uart_int || (tx_full && gap == '0)) begin
            state <= ST_RD;
            cs    <= 1'b1;
            addr  <= ADDR_STATUS;
          end else begin
            cfg_ready <= 1'b1;
            if (gap != '0) gap <= GAP_W'(gap - 1'b1);
          end
        end

        CFG_WR: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end

        ST_RD: state <= ST_WAIT;

        // Status decode: RX service wins over TX; a TX write uses the register
        // content as of this cycle, not a byte accepted in the same cycle.
        ST_WAIT: begin
          if (datout[0]) begin
            state <= RX_RD;
            cs    <= 1'b1;
            addr  <= ADDR_DATA;
          end else if (datout[1] && tx_full) begin
            state <= TX_WR;
            cs    <= 1'b1;
            nrw   <= 1'b1;
            addr  <= ADDR_DATA;
            datin <= tx_hold;
          end else begin
            state     <= IDLE;
            gap       <= GAP_RELOAD;
            cfg_ready <= 1'b1;
          end
        end

        RX_RD: state <= RX_WAIT;

        RX_WAIT: begin
          state     <= IDLE;
          rx_data   <= datout;
          rx_valid  <= 1'b1;
          cfg_ready <= 1'b1;
        end

        TX_WR: begin
          state     <= IDLE;
          tx_full   <= 1'b0;
          tx_ready  <= 1'b1;
          cfg_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_seq.sv
// tb_uart_host_seq: directed cycle table for the documented scenarios, then a
// randomized run scored against a transaction-level model of the UART host.
module tb_uart_host_seq;

  localparam int unsigned GAP       = 4;
  localparam int          RAND_CYC  = 3000;
  localparam int          DRAIN_CYC = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       uart_int = 1'b0;
  logic       cs;
  logic       nrw;
  logic [2:0] addr;
  logic [7:0] datin;
  logic [7:0] datout = 8'h00;

  always #5 clk = ~clk;

  uart_host_seq #(.POLL_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .uart_int(uart_int),
    .cs(cs), .nrw(nrw), .addr(addr), .datin(datin), .datout(datout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One record per clock: inputs applied this cycle, outputs expected this cycle.
  typedef struct {
    logic       chk, rst, txv;
    logic [7:0] txd;
    logic       cfv;
    logic [2:0] cfa;
    logic [7:0] cfd;
    logic       irq;
    logic [7:0] dout;
    logic       cs, nrw;
    logic [2:0] addr;
    logic [7:0] datin;
    logic       txr, cfr, rxv;
    logic [7:0] rxd;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input int c, r, tv, td, cv, ca, cd, ir, dout,
                            e_cs, e_nrw, e_addr, e_datin, e_txr, e_cfr, e_rxv, e_rxd);
    vec_t t;
    t.chk = 1'(c);   t.rst = 1'(r);   t.txv = 1'(tv);  t.txd = 8'(td);
    t.cfv = 1'(cv);  t.cfa = 3'(ca);  t.cfd = 8'(cd);  t.irq = 1'(ir);
    t.dout = 8'(dout);
    t.cs = 1'(e_cs); t.nrw = 1'(e_nrw); t.addr = 3'(e_addr); t.datin = 8'(e_datin);
    t.txr = 1'(e_txr); t.cfr = 1'(e_cfr); t.rxv = 1'(e_rxv); t.rxd = 8'(e_rxd);
    tbl.push_back(t);
  endfunction

  function automatic void build_table();
    // reset, then TX of 0xA5 with status 0x02
    v(0,1,0,0,0,0,0,0,0,        0,0,0,0,1,1,0,0);
    v(1,0,1,'hA5,0,0,0,0,0,     0,0,0,0,1,1,0,0);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0,0);
    v(1,0,0,0,0,0,0,0,0,        1,0,1,0,0,0,0,0);
    v(1,0,0,0,0,0,0,0,'h02,     0,0,0,0,0,0,0,0);
    v(1,0,0,0,0,0,0,0,0,        1,1,0,'hA5,0,0,0,0);
    // byte 0x11 pending, fruitless polls 7 cycles apart
    v(1,0,1,'h11,0,0,0,0,0,     0,0,0,0,1,1,0,0);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0,0);
    for (int p = 0; p < 2; p++) begin
      v(1,0,0,0,0,0,0,0,0,      1,0,1,0,0,0,0,0);
      v(1,0,0,0,0,0,0,0,'h00,   0,0,0,0,0,0,0,0);
      for (int q = 0; q < 5; q++) v(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,0);
    end
    v(1,0,0,0,0,0,0,0,0,        1,0,1,0,0,0,0,0);
    v(1,0,0,0,0,0,0,0,'h02,     0,0,0,0,0,0,0,0);
    v(1,0,0,0,0,0,0,0,0,        1,1,0,'h11,0,0,0,0);
    // interrupt, status 0x01, RX byte 0x3C
    v(1,0,0,0,0,0,0,1,0,        0,0,0,0,1,1,0,0);
    v(1,0,0,0,0,0,0,0,0,        1,0,1,0,1,0,0,0);
    v(1,0,0,0,0,0,0,0,'h01,     0,0,0,0,1,0,0,0);
    v(1,0,0,0,0,0,0,0,'h77,     1,0,0,0,1,0,0,0);
    v(1,0,0,0,0,0,0,0,'h3C,     0,0,0,0,1,0,0,0);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,0,1,1,1,'h3C);
    // cfg + tx + int together; then status 0x03, 0x02
    v(1,0,1,'h42,1,3,'h83,1,0,  0,0,0,0,1,1,0,'h3C);
    v(1,0,0,0,0,0,0,1,0,        1,1,3,'h83,0,0,0,'h3C);
    v(1,0,0,0,0,0,0,1,0,        0,0,0,0,0,1,0,'h3C);
    v(1,0,0,0,0,0,0,0,0,        1,0,1,0,0,0,0,'h3C);
    v(1,0,0,0,0,0,0,0,'h03,     0,0,0,0,0,0,0,'h3C);
    v(1,0,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,'h3C);
    v(1,0,0,0,0,0,0,0,'h9E,     0,0,0,0,0,0,0,'h3C);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,1,'h9E);
    v(1,0,0,0,0,0,0,0,0,        1,0,1,0,0,0,0,'h9E);
    v(1,0,0,0,0,0,0,0,'h02,     0,0,0,0,0,0,0,'h9E);
    v(1,0,0,0,0,0,0,0,0,        1,1,0,'h42,0,0,0,'h9E);
    // reset during TX_WR of 0x5A
    v(1,0,1,'h5A,0,0,0,0,0,     0,0,0,0,1,1,0,'h9E);
    v(1,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0,'h9E);
    v(1,0,0,0,0,0,0,0,0,        1,0,1,0,0,0,0,'h9E);
    v(1,0,0,0,0,0,0,0,'h02,     0,0,0,0,0,0,0,'h9E);
    v(1,1,0,0,0,0,0,0,0,        1,1,0,'h5A,0,0,0,'h9E);
    for (int q = 0; q < 5; q++) v(1,0,0,0,0,0,0,0,'h02, 0,0,0,0,1,1,0,0);
  endfunction

  // Transaction-level model state for the random run
  logic [7:0]  tx_q[$];
  logic [10:0] cfg_q[$];
  int          status_at, exp_rx_at, exp_tx_at, exp_rxv_at, rx_rd_seen, fruitless_at;
  logic [1:0]  last_status;
  logic [7:0]  exp_rxd, cur_rxd, resp;
  bit          disturbed, gap_pend, prev_cs, resp_prev, resp_now, drain, cfr_exp, txr_exp;

  initial begin
    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (tbl[i].chk) begin
        check("dir_cs",        i, 32'(cs),        32'(tbl[i].cs));
        check("dir_nrw",       i, 32'(nrw),       32'(tbl[i].nrw));
        check("dir_addr",      i, 32'(addr),      32'(tbl[i].addr));
        check("dir_datin",     i, 32'(datin),     32'(tbl[i].datin));
        check("dir_tx_ready",  i, 32'(tx_ready),  32'(tbl[i].txr));
        check("dir_cfg_ready", i, 32'(cfg_ready), 32'(tbl[i].cfr));
        check("dir_rx_valid",  i, 32'(rx_valid),  32'(tbl[i].rxv));
        check("dir_rx_data",   i, 32'(rx_data),   32'(tbl[i].rxd));
      end
      rst = tbl[i].rst;       tx_valid = tbl[i].txv;  tx_data = tbl[i].txd;
      cfg_valid = tbl[i].cfv; cfg_addr = tbl[i].cfa;  cfg_data = tbl[i].cfd;
      uart_int = tbl[i].irq;  datout = tbl[i].dout;
    end

    // Random phase from a fresh reset
    @(negedge clk);
    rst = 1'b1; tx_valid = 1'b0; cfg_valid = 1'b0; uart_int = 1'b0; datout = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    status_at = -10; exp_rx_at = -10; exp_tx_at = -10; exp_rxv_at = -10;
    rx_rd_seen = -10; fruitless_at = -10;
    cur_rxd = 8'h00; prev_cs = 1'b0; resp_prev = 1'b0; disturbed = 1'b0; gap_pend = 1'b0;

    for (int k = 0; k < RAND_CYC + DRAIN_CYC; k++) begin
      @(negedge clk);
      drain = (k >= RAND_CYC);
      resp_now = 1'b0;
      resp = 8'h00;
      txr_exp = (tx_q.size() == 0);
      check("tx_ready", k, 32'(tx_ready), 32'(txr_exp));
      if (k == exp_rxv_at) cur_rxd = exp_rxd;
      check("rx_valid", k, 32'(rx_valid), 32'(k == exp_rxv_at));
      check("rx_data",  k, 32'(rx_data),  32'(cur_rxd));
      if (k == fruitless_at + 2) gap_pend = (tx_q.size() != 0);

      // Cycle after a status read: RX first, then TX if a byte is held, else back off.
      if (k == status_at + 1) begin
        if (last_status[0]) exp_rx_at = k + 1;
        else if (last_status[1] && tx_q.size() != 0) exp_tx_at = k + 1;
        else begin
          fruitless_at = status_at;
          disturbed    = 1'b0;
        end
      end

      // Idle unless on an access or waiting for read data.
      cfr_exp = !(cs || k == status_at + 1 || k == rx_rd_seen + 1);
      check("cfg_ready", k, 32'(cfg_ready), 32'(cfr_exp));

      if (k == exp_tx_at) check("tx_wr_cs", k, 32'(cs), 32'(1));
      if (k == exp_rx_at) check("rx_rd_cs", k, 32'(cs), 32'(1));
      if (cs) begin
        check("cs_back_to_back", k, 32'(prev_cs), 32'(0));
        if (k == exp_tx_at) begin
          check("tx_wr_nrw",  k, 32'(nrw),  32'(1));
          check("tx_wr_addr", k, 32'(addr), 32'(0));
          if (tx_q.size() != 0) begin
            check("tx_wr_data", k, 32'(datin), 32'(tx_q[0]));
            void'(tx_q.pop_front());
          end
        end else if (k == exp_rx_at) begin
          check("rx_rd_nrw",  k, 32'(nrw),  32'(0));
          check("rx_rd_addr", k, 32'(addr), 32'(0));
          resp = 8'($urandom);
          resp_now = 1'b1;
          exp_rxd = resp;
          exp_rxv_at = k + 2;
          rx_rd_seen = k;
        end else if (!nrw) begin
          check("st_rd_addr",  k, 32'(addr),  32'(1));
          check("st_rd_datin", k, 32'(datin), 32'(0));
          if (fruitless_at >= 0 && !disturbed) begin
            if (gap_pend) check("poll_gap_exact", k, 32'(k - fruitless_at), 32'(GAP + 3));
            else          check("poll_gap_min",   k, 32'(k - fruitless_at >= int'(GAP + 3)), 32'(1));
          end
          fruitless_at = -10;
          resp = drain ? 8'h02 : 8'($urandom_range(0, 3));
          resp_now = 1'b1;
          last_status = resp[1:0];
          status_at = k;
        end else begin
          check("cfg_wr_queued", k, 32'(cfg_q.size() != 0), 32'(1));
          if (cfg_q.size() != 0) begin
            check("cfg_wr", k, 32'({addr, datin}), 32'(cfg_q[0]));
            void'(cfg_q.pop_front());
          end
        end
      end else begin
        check("bus_idle", k, 32'({nrw, addr, datin}), 32'(0));
      end
      prev_cs = cs;

      // Drive next cycle; read data is held through the cycle it is sampled.
      if (resp_now) datout = resp;
      else if (!resp_prev) datout = 8'($urandom);
      resp_prev = resp_now;
      tx_valid = !drain && ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      if (tx_valid && txr_exp) tx_q.push_back(tx_data);
      cfg_valid = !drain && ($urandom_range(0, 11) == 0);
      cfg_addr  = 3'($urandom);
      cfg_data  = 8'($urandom);
      if (cfg_valid && cfr_exp) cfg_q.push_back({cfg_addr, cfg_data});
      uart_int = !drain && ($urandom_range(0, 19) == 0);
      if (k >= fruitless_at + 2 && (uart_int || (cfg_valid && cfr_exp))) disturbed = 1'b1;
    end

    check("cfg_all_written", RAND_CYC + DRAIN_CYC, 32'(cfg_q.size()), 32'(0));
    check("tx_all_written",  RAND_CYC + DRAIN_CYC, 32'(tx_q.size()),  32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_host_seq.md
UART_HOST_SEQ -- requirements
Module: uart_host_seq

Interface
REQ-001 Parameter: POLL_GAP, 4, number of decrementing IDLE cycles between a fruitless status poll and the next poll; range 0..255.
REQ-002 The design SHALL use one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 tx_valid  in  1  host offers a byte to transmit.
REQ-006 tx_data  in  8  byte to transmit.
REQ-007 tx_ready  out  1  holding register empty; byte accepted when tx_valid&tx_ready.
REQ-008 cfg_valid  in  1  host requests a UART register write.
REQ-009 cfg_addr  in  3  target UART register address.
REQ-010 cfg_data  in  8  value to write.
REQ-011 cfg_ready  out  1  config request accepted this cycle when cfg_valid&cfg_ready.
REQ-012 rx_valid  out  1  one-cycle strobe, received byte on rx_data.
REQ-013 rx_data  out  8  received byte, held until next rx_valid.
REQ-014 int  in  1  UART interrupt, active high.
REQ-015 cs, nrw, addr[2:0], datin[7:0]  out  UART bus: chip select, read(0)/write(1), address, write data.
REQ-016 datout  in  8  UART read data, valid the cycle after a read access.

Function
REQ-017 UART map SHALL be: addr 0 = TX data (write) / RX data (read); addr 1 = status, bit0 RX full, bit1 TX empty.
REQ-018 FSM states SHALL be IDLE, CFG_WR, ST_RD, ST_WAIT, RX_RD, RX_WAIT, TX_WR; bus outputs decoded from state only.
REQ-019 Outside CFG_WR/ST_RD/RX_RD/TX_WR, bus SHALL drive cs=0, nrw=0, addr=0, datin=0.
REQ-020 IDLE priority SHALL be: cfg_valid -> CFG_WR; else int=1 -> ST_RD (ignores gap); else tx_full and gap==0 -> ST_RD; else stay, gap decrements if nonzero.
REQ-021 cfg_ready SHALL equal (state==IDLE); cfg_addr/cfg_data captured on acceptance.
REQ-022 CFG_WR: cs=1, nrw=1, addr=captured addr, datin=captured data, one cycle -> IDLE.
REQ-023 ST_RD: cs=1, nrw=0, addr=1, one cycle -> ST_WAIT.
REQ-024 ST_WAIT: sample datout; bit0=1 -> RX_RD; else bit1=1 and tx_full -> TX_WR; else gap<=POLL_GAP, -> IDLE.
REQ-025 RX_RD: cs=1, nrw=0, addr=0 -> RX_WAIT; RX_WAIT: rx_data<=datout, rx_valid=1 next cycle only, -> IDLE.
REQ-026 TX_WR: cs=1, nrw=1, addr=0, datin=holding register; tx_full cleared at end of cycle -> IDLE.
REQ-027 tx_ready SHALL equal ~tx_full; acceptance allowed in any state, including same cycle as CFG_WR or ST_WAIT.
REQ-028 RX service SHALL precede TX when status=0x03; TX then requires a fresh poll.
REQ-029 With POLL_GAP=N and no int/cfg, exactly N+1 IDLE cycles SHALL separate a fruitless ST_WAIT and the next ST_RD.
REQ-030 Each bus access SHALL be exactly one cs cycle; cs never high in consecutive cycles.

Reset
REQ-031 rst=1 at any clock edge SHALL force next-cycle state IDLE, cs=0, nrw=0, addr=0, datin=0, tx_full=0 (pending byte discarded), gap=0, rx_valid=0, rx_data=0x00, cfg capture=0.
REQ-032 Reset mid-access SHALL abort it; no further cs pulse for the aborted transaction.

Verification
REQ-033 rst during TX_WR with tx byte 0x5A pending -> next cycle cs=0, tx_ready=1; no write of 0x5A after release.
REQ-034 tx_valid, tx_data=0xA5, datout status=0x02 -> ST_RD (cs,addr=1,nrw=0), ST_WAIT, TX_WR (cs,nrw=1,addr=0,datin=0xA5); tx_ready=1 the cycle after TX_WR.
REQ-035 tx byte pending, status=0x00, POLL_GAP=4 -> status polls every 7 cycles (ST_RD, ST_WAIT, 5 IDLE), no TX write until status=0x02.
REQ-036 int=1, status=0x01, data read datout=0x3C -> RX_RD cs addr=0, rx_valid high exactly one cycle with rx_data=0x3C.
REQ-037 cfg_valid (addr=3, data=0x83), tx_valid, int all in the same IDLE cycle -> CFG_WR (addr=3, datin=0x83) first, then ST_RD; tx byte accepted in that first cycle.
REQ-038 tx pending, status=0x03, then 0x02 -> RX read first, rx_valid pulse, second poll, then TX write.
